// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared definitions for the frame buffer and the capture / VGA blocks that use it.
package frame_buffer_ctrl_pkg;

  localparam int unsigned PIXEL_DW = 12;

  localparam logic [PIXEL_DW-1:0] COLOR_BLACK = 12'h000;
  localparam logic [PIXEL_DW-1:0] COLOR_WHITE = 12'hFFF;
  localparam logic [PIXEL_DW-1:0] COLOR_RED   = 12'hF00;

  typedef enum logic [1:0] {
    FB_IDLE  = 2'd0,
    FB_CLEAR = 2'd1,
    FB_DONE  = 2'd2
  } fb_state_e;

  // Where the visible read pixel comes from: nothing yet (after reset), RAM, or background.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_RAM  = 2'd1,
    RD_BG   = 2'd2
  } rd_src_e;

  function automatic int unsigned npix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/fb_ram_core.sv
// Simple dual-port, single-clock, read-first pixel RAM.
module fb_ram_core #(
  parameter int unsigned AW        = 15,
  parameter int unsigned DW        = 12,
  parameter              INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write and read in the same process so a same-address read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Frame buffer controller: port writes, registered reads with background fill, clear sweep.
module frame_buffer_ctrl
  import frame_buffer_ctrl_pkg::*;
#(
  parameter int unsigned   AW        = 15,
  parameter int unsigned   DW        = PIXEL_DW,
  parameter int unsigned   IMG_W     = 160,
  parameter int unsigned   IMG_H     = 120,
  parameter logic [DW-1:0] BG_COLOR  = DW'(COLOR_BLACK),
  parameter                INIT_FILE = ""
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_drop_o,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o,
  input  logic          clear_req_i,
  input  logic [DW-1:0] clear_color_i,
  output logic          busy_o,
  output logic          clear_done_o
);

  localparam int unsigned NPIX      = npix(IMG_W, IMG_H);
  localparam int unsigned AW1       = AW + 1;
  localparam logic [AW:0]   NPIX_W    = AW1'(NPIX);
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  fb_state_e     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic          wr_drop_q, wr_drop_d;
  logic          rd_valid_q, rd_valid_d;
  rd_src_e       rd_src_q, rd_src_d;

  logic          busy;
  logic          wr_in_img;
  logic          rd_in_img;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;

  assign busy      = (state_q != FB_IDLE);
  assign wr_in_img = ({1'b0, wr_addr_i} < NPIX_W);
  assign rd_in_img = ({1'b0, rd_addr_i} < NPIX_W);
  assign ram_re    = rd_en_i && rd_in_img;

  // Sweep sequencing: accept a clear in IDLE, walk every pixel once, then flag completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    unique case (state_q)
      FB_IDLE: begin
        if (clear_req_i) begin
          state_d = FB_CLEAR;
          cnt_d   = '0;
          color_d = clear_color_i;
        end
      end
      FB_CLEAR: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = FB_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FB_DONE: begin
        state_d = FB_IDLE;
      end
      default: begin
        state_d = FB_IDLE;
      end
    endcase
  end

  // RAM write port belongs to the sweep while clearing, otherwise to in-image port writes in IDLE.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr_i;
    ram_wdata = wr_data_i;
    if (state_q == FB_CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = cnt_q;
      ram_wdata = color_q;
    end else if ((state_q == FB_IDLE) && wr_en_i && wr_in_img) begin
      ram_we = 1'b1;
    end
  end

  // Next values for the drop pulse and the read result bookkeeping.
  always_comb begin
    wr_drop_d  = wr_en_i && (busy || !wr_in_img);
    rd_valid_d = rd_en_i;
    rd_src_d   = rd_src_q;
    if (rd_en_i) begin
      rd_src_d = rd_in_img ? RD_RAM : RD_BG;
    end
  end

  // All controller state; RAM contents are deliberately outside the reset domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= FB_IDLE;
      cnt_q      <= '0;
      color_q    <= '0;
      wr_drop_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_src_q   <= RD_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      color_q    <= color_d;
      wr_drop_q  <= wr_drop_d;
      rd_valid_q <= rd_valid_d;
      rd_src_q   <= rd_src_d;
    end
  end

  // Out-of-image reads never touch the RAM; the stored source selects background instead.
  always_comb begin
    rd_data_o = '0;
    unique case (rd_src_q)
      RD_RAM:  rd_data_o = ram_rdata;
      RD_BG:   rd_data_o = BG_COLOR;
      default: rd_data_o = '0;
    endcase
  end

  assign wr_drop_o    = wr_drop_q;
  assign rd_valid_o   = rd_valid_q;
  assign busy_o       = busy;
  assign clear_done_o = (state_q == FB_DONE);

  fb_ram_core #(
    .AW        (AW),
    .DW        (DW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr_i),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl on a reduced 16x12 image.
module tb_frame_buffer_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 12;
  localparam int IMG_W = 16;
  localparam int IMG_H = 12;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int DEPTH = 1 << AW;
  localparam logic [DW-1:0] BG = 12'h5A5;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_drop;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          clear_req;
  logic [DW-1:0] clear_color;
  logic          busy;
  logic          clear_done;

  // Reference image: what each in-image pixel should hold, and whether it is known yet.
  logic [DW-1:0] model_mem [NPIX];
  bit            model_known [NPIX];

  int compared;
  int mismatched;

  frame_buffer_ctrl #(
    .AW        (AW),
    .DW        (DW),
    .IMG_W     (IMG_W),
    .IMG_H     (IMG_H),
    .BG_COLOR  (BG),
    .INIT_FILE ("")
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .wr_en_i       (wr_en),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_drop_o     (wr_drop),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .clear_req_i   (clear_req),
    .clear_color_i (clear_color),
    .busy_o        (busy),
    .clear_done_o  (clear_done)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    clear_req = 1'b0; clear_color = '0;
    repeat (3) tick();
    compared++;
    if (rd_data !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_rd_data got=%h exp=000", rd_data); end
    compared++;
    if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    compared++;
    if (wr_drop !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_wr_drop got=%b exp=0", wr_drop); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    compared++;
    if (clear_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_clear_done got=%b exp=0", clear_done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_write_read();
    int addrs[$];
    for (int i = 0; i < 24; i++) begin
      int a;
      logic [DW-1:0] d;
      a = $urandom_range(NPIX - 1, 0);
      d = DW'($urandom);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      tick();
      compared++;
      if (wr_drop !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_drop_in_image addr=%0d got=%b exp=0", a, wr_drop); end
      model_mem[a] = d;
      model_known[a] = 1'b1;
      addrs.push_back(a);
    end
    wr_en = 1'b0;
    foreach (addrs[i]) begin
      rd_en = 1'b1; rd_addr = AW'(addrs[i]);
      tick();
      compared++;
      if (rd_data !== model_mem[addrs[i]]) begin
        mismatched++; $display("[TB] FAIL read_back addr=%0d got=%h exp=%h", addrs[i], rd_data, model_mem[addrs[i]]);
      end
      compared++;
      if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL read_valid addr=%0d got=%b exp=1", addrs[i], rd_valid); end
    end
    rd_en = 1'b0;
    tick();
    compared++;
    if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_rd_valid got=%b exp=0", rd_valid); end
    compared++;
    if (rd_data !== model_mem[addrs[$]]) begin
      mismatched++; $display("[TB] FAIL rd_data_hold got=%h exp=%h", rd_data, model_mem[addrs[$]]);
    end
  endtask

  task automatic test_read_first();
    int a;
    logic [DW-1:0] old_v;
    logic [DW-1:0] new_v;
    a = 100;
    old_v = 12'h3C3;
    new_v = 12'hABC;
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = old_v;
    tick();
    rd_en = 1'b1; rd_addr = AW'(a);
    wr_en = 1'b1; wr_data = new_v;
    tick();
    compared++;
    if (rd_data !== old_v) begin mismatched++; $display("[TB] FAIL read_first got=%h exp=%h", rd_data, old_v); end
    wr_en = 1'b0;
    tick();
    compared++;
    if (rd_data !== new_v) begin mismatched++; $display("[TB] FAIL read_after_write got=%h exp=%h", rd_data, new_v); end
    rd_en = 1'b0;
    model_mem[a] = new_v;
    model_known[a] = 1'b1;
  endtask

  task automatic test_out_of_range();
    int oob[$];
    oob.push_back(NPIX);
    oob.push_back(DEPTH - 1);
    oob.push_back($urandom_range(DEPTH - 2, NPIX + 1));
    foreach (oob[i]) begin
      wr_en = 1'b1; wr_addr = AW'(oob[i]); wr_data = DW'($urandom);
      rd_en = 1'b1; rd_addr = AW'(oob[i]);
      tick();
      compared++;
      if (wr_drop !== 1'b1) begin mismatched++; $display("[TB] FAIL oob_wr_drop addr=%0d got=%b exp=1", oob[i], wr_drop); end
      compared++;
      if (rd_data !== BG) begin mismatched++; $display("[TB] FAIL oob_read addr=%0d got=%h exp=%h", oob[i], rd_data, BG); end
      compared++;
      if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL oob_rd_valid addr=%0d got=%b exp=1", oob[i], rd_valid); end
      wr_en = 1'b0; rd_en = 1'b0;
      tick();
      compared++;
      if (wr_drop !== 1'b0) begin mismatched++; $display("[TB] FAIL wr_drop_one_cycle got=%b exp=0", wr_drop); end
      compared++;
      if (rd_data !== BG) begin mismatched++; $display("[TB] FAIL oob_hold got=%h exp=%h", rd_data, BG); end
    end
    // In-image pixels must be untouched by the discarded writes.
    rd_en = 1'b1; rd_addr = AW'(100);
    tick();
    compared++;
    if (rd_data !== model_mem[100]) begin mismatched++; $display("[TB] FAIL oob_no_alias got=%h exp=%h", rd_data, model_mem[100]); end
    rd_en = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cycles;
    int done_cnt;
    int done_at;
    logic [DW-1:0] color;
    color = 12'hF00;
    clear_req = 1'b1; clear_color = color;
    wr_en = 1'b1; wr_addr = '0; wr_data = 12'h123;
    tick();
    clear_req = 1'b0; wr_en = 1'b0;
    busy_cycles = 0; done_cnt = 0; done_at = 0;
    while (busy === 1'b1 && busy_cycles < NPIX + 20) begin
      busy_cycles++;
      if (clear_done === 1'b1) begin done_cnt++; done_at = busy_cycles; end
      if (busy_cycles == 1) begin
        compared++;
        if (wr_drop !== 1'b0) begin mismatched++; $display("[TB] FAIL simul_write_drop got=%b exp=0", wr_drop); end
      end
      if (busy_cycles == 51) begin
        compared++;
        if (wr_drop !== 1'b1) begin mismatched++; $display("[TB] FAIL busy_wr_drop got=%b exp=1", wr_drop); end
      end
      wr_en = (busy_cycles == 50); wr_addr = AW'(50); wr_data = 12'h777;
      clear_req = (busy_cycles == 50); clear_color = 12'h0F0;
      tick();
    end
    wr_en = 1'b0; clear_req = 1'b0;
    compared++;
    if (busy_cycles != NPIX + 1) begin mismatched++; $display("[TB] FAIL busy_length got=%0d exp=%0d", busy_cycles, NPIX + 1); end
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("[TB] FAIL done_count got=%0d exp=1", done_cnt); end
    compared++;
    if (done_at != NPIX + 1) begin mismatched++; $display("[TB] FAIL done_position got=%0d exp=%0d", done_at, NPIX + 1); end
    for (int a = 0; a < NPIX; a++) begin
      model_mem[a] = color;
      model_known[a] = 1'b1;
    end
    // Back-to-back readback of the whole image.
    for (int a = 0; a < NPIX; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      compared++;
      if (rd_data !== model_mem[a] || rd_valid !== 1'b1) begin
        mismatched++; $display("[TB] FAIL clear_readback addr=%0d got=%h/%b exp=%h/1", a, rd_data, rd_valid, model_mem[a]);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int m;
    logic [DW-1:0] color;
    m = $urandom_range(NPIX - 10, 10);
    color = 12'h00F;
    clear_req = 1'b1; clear_color = color;
    tick();
    clear_req = 1'b0;
    repeat (m) tick();
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL pre_reset_busy got=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_busy got=%b exp=0", busy); end
    compared++;
    if (clear_done !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_done got=%b exp=0", clear_done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < m; a++) model_mem[a] = color;
    for (int a = 0; a < NPIX; a++) begin
      rd_en = 1'b1; rd_addr = AW'(a);
      tick();
      compared++;
      if (rd_data !== model_mem[a]) begin
        mismatched++; $display("[TB] FAIL partial_clear addr=%0d cut=%0d got=%h exp=%h", a, m, rd_data, model_mem[a]);
      end
    end
    rd_en = 1'b0;
    tick();
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL after_partial_busy got=%b exp=0", busy); end
  endtask

  // Scenario sequence and final summary.
  initial begin
    compared = 0;
    mismatched = 0;
    for (int a = 0; a < NPIX; a++) begin
      model_mem[a] = '0;
      model_known[a] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_read_first();
    test_out_of_range();
    test_clear();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
